mdc_stream: RTL and testbench

Parametrised greatest-common-divisor (MDC) engine with valid/ready handshakes on both sides, replacing the fixed 8-bit, free-running MDC unit. It accepts one operand pair, iterates subtractive Euclid one step per clock, and holds the result until the consumer takes it. It sits between an operand source and a result sink in the arithmetic datapath and tolerates back-pressure on either side.

---
 rtl/mdc_pkg.sv | 12 +
 rtl/mdc_step.sv | 35 +++
 rtl/mdc_stream.sv | 117 +++++++++++
 tb/tb_mdc_stream.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdc_pkg.sv
// Shared types and defaults for the streaming GCD engine.
package mdc_pkg;

    localparam int MDC_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mdc_step.sv
// One subtractive-Euclid step: reduces the larger operand or reports the result.
module mdc_step
    import mdc_pkg::*;
#(
    parameter int WIDTH = MDC_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] a_nxt,
    output logic [WIDTH-1:0] b_nxt,
    output logic [WIDTH-1:0] res,
    output logic             done,
    output logic             zero
);

    always_comb begin
        a_nxt = a;
        b_nxt = b;
        res   = a | b;
        done  = 1'b0;
        zero  = 1'b0;
        if (a == '0 || b == '0) begin
            done = 1'b1;
            zero = (a == '0) && (b == '0);
        end else if (a == b) begin
            done = 1'b1;
            res  = a;
        end else if (a > b) begin
            a_nxt = a - b;
        end else begin
            b_nxt = b - a;
        end
    end

endmodule

// File: rtl/mdc_stream.sv
// Handshaked GCD engine: accept a pair, iterate one Euclid step per clock, hold result.
// Optional CALC-cycle counter on cyc_o when MDC_CYCLE_CNT_EN is defined.
module mdc_stream
    import mdc_pkg::*;
#(
    parameter int WIDTH = MDC_WIDTH,
    parameter int CNT_W = WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] dtx_i,
    input  logic [WIDTH-1:0] dty_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] dt_o,
    output logic             zero_o
`ifdef MDC_CYCLE_CNT_EN
    ,
    output logic [CNT_W-1:0] cyc_o
`endif
);

    if (WIDTH < 2 || CNT_W < 1) begin : g_bad_cfg
        $error("mdc_stream: WIDTH must be >= 2 and CNT_W >= 1");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, dt_q;
    logic             zero_q;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             accept;

    logic [WIDTH-1:0] step_a, step_b, step_res;
    logic             step_done, step_zero;

    mdc_step #(.WIDTH(WIDTH)) u_step (
        .a     (a_q),
        .b     (b_q),
        .a_nxt (step_a),
        .b_nxt (step_b),
        .res   (step_res),
        .done  (step_done),
        .zero  (step_zero)
    );

    assign accept = in_valid_i && in_ready_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)      state_d = CALC;
            CALC:    if (step_done)   state_d = DONE;
            DONE:    if (out_ready_i) state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // Handshake flags are decoded from the next state so they leave a flop.
    always_comb begin
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q    <= '0;
            b_q    <= '0;
            dt_q   <= '0;
            zero_q <= 1'b0;
        end else if (accept) begin
            a_q <= dtx_i;
            b_q <= dty_i;
        end else if (state_q == CALC) begin
            a_q <= step_a;
            b_q <= step_b;
            if (step_done) begin
                dt_q   <= step_res;
                zero_q <= step_zero;
            end
        end
    end

`ifdef MDC_CYCLE_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Counts every CALC cycle including the exit one, so it equals k at DONE.
    always_ff @(posedge clk_i) begin
        if (rst_i || accept)
            cnt_q <= '0;
        else if (state_q == CALC && cnt_q != {CNT_W{1'b1}})
            cnt_q <= cnt_q + 1'b1;
    end

    assign cyc_o = cnt_q;
`endif

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign dt_o        = dt_q;
    assign zero_o      = zero_q;

endmodule

// File: tb/tb_mdc_stream.sv
// Self-checking bench for mdc_stream: directed table, hand sequences, random vs GCD model.
module tb_mdc_stream;

    localparam int CW8  = 8;
    localparam int CW16 = 7;
    localparam int N8   = 1000;
    localparam int N16  = 200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        iv8, ir8, ov8, or8, z8;
    logic [7:0]  x8, y8, d8;
    logic        iv16, ir16, ov16, or16, z16;
    logic [15:0] x16, y16, d16;
`ifdef MDC_CYCLE_CNT_EN
    logic [CW8-1:0]  c8;
    logic [CW16-1:0] c16;
`endif

    mdc_stream #(.WIDTH(8), .CNT_W(CW8)) dut8 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(iv8), .in_ready_o(ir8),
        .dtx_i(x8), .dty_i(y8), .out_valid_o(ov8), .out_ready_i(or8),
        .dt_o(d8), .zero_o(z8)
`ifdef MDC_CYCLE_CNT_EN
        , .cyc_o(c8)
`endif
    );

    mdc_stream #(.WIDTH(16), .CNT_W(CW16)) dut16 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(iv16), .in_ready_o(ir16),
        .dtx_i(x16), .dty_i(y16), .out_valid_o(ov16), .out_ready_i(or16),
        .dt_o(d16), .zero_o(z16)
`ifdef MDC_CYCLE_CNT_EN
        , .cyc_o(c16)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Reference: Euclid by division; CALC cycles = sum of quotients (1 for a zero operand).
    function automatic void gcd_model(input int x, input int y,
                                      output int dt, output int z, output int k);
        int a = x;
        int b = y;
        int r;
        if (x == 0 || y == 0) begin
            dt = x | y; z = (x == 0 && y == 0) ? 1 : 0; k = 1;
            return;
        end
        k = 0;
        while (b != 0) begin
            k += a / b; r = a % b; a = b; b = r;
        end
        dt = a; z = 0;
    endfunction

    function automatic int sat(input int k, input int cw);
        int mx = (1 << cw) - 1;
        return (k > mx) ? mx : k;
    endfunction

    typedef struct {
        int x; int y; int dt; int zero; int k;
    } vec_t;
    vec_t tbl[11];

    // Drives one pair into dut8 with out_ready held high and checks result and latency.
    task automatic run_pair(input int x, input int y, input int edt, input int ez,
                            input int ek, input string tag);
        int n;
        @(negedge clk);
        chk({tag, " in_ready"}, ir8, 1);
        x8 = x[7:0]; y8 = y[7:0]; iv8 = 1'b1; or8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0; x8 = 8'($urandom); y8 = 8'($urandom);
        @(negedge clk);
        chk({tag, " busy"}, {ir8, ov8}, 0);
        n = 1;
        while (!ov8 && n < 70000) begin
            @(negedge clk);
            if (!ov8) n++;
            x8 = 8'($urandom); y8 = 8'($urandom);
        end
        chk({tag, " cycles"}, n, ek);
        chk({tag, " dt"}, d8, edt);
        chk({tag, " zero"}, z8, ez);
`ifdef MDC_CYCLE_CNT_EN
        chk({tag, " cyc"}, c8, sat(ek, CW8));
`endif
        @(posedge clk);
    endtask

    initial begin
        tbl[0]  = '{12, 8, 4, 0, 3};
        tbl[1]  = '{0, 0, 0, 1, 1};
        tbl[2]  = '{0, 9, 9, 0, 1};
        tbl[3]  = '{7, 7, 7, 0, 1};
        tbl[4]  = '{9, 0, 9, 0, 1};
        tbl[5]  = '{255, 1, 1, 0, 255};
        tbl[6]  = '{1, 255, 1, 0, 255};
        tbl[7]  = '{255, 255, 255, 0, 1};
        tbl[8]  = '{128, 96, 32, 0, 4};
        tbl[9]  = '{100, 75, 25, 0, 4};
        tbl[10] = '{1, 1, 1, 0, 1};

        rst = 1'b1;
        iv8 = 1'b0; or8 = 1'b0; x8 = '0; y8 = '0;
        iv16 = 1'b0; or16 = 1'b0; x16 = '0; y16 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset rdy/vld8", {ir8, ov8, z8}, 0);
        chk("reset dt8", d8, 0);
        chk("reset rdy/vld16", {ir16, ov16, z16}, 0);
        chk("reset dt16", d16, 0);
`ifdef MDC_CYCLE_CNT_EN
        chk("reset cyc8", c8, 0);
        chk("reset cyc16", c16, 0);
`endif
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset ready", {ir8, ir16}, 2'b11);

        for (int i = 0; i < 11; i++)
            run_pair(tbl[i].x, tbl[i].y, tbl[i].dt, tbl[i].zero, tbl[i].k,
                     $sformatf("vec%0d", i));

        // Back-pressure: result held, new pair refused until the sink takes it.
        begin : bp
            int n;
            @(negedge clk);
            x8 = 8'd12; y8 = 8'd8; iv8 = 1'b1; or8 = 1'b0;
            @(posedge clk); #1;
            iv8 = 1'b0;
            n = 0;
            while (!ov8 && n < 100) begin
                @(negedge clk); n++;
            end
            chk("bp valid", ov8, 1);
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                x8 = 8'd50; y8 = 8'd5; iv8 = 1'b1;
                chk("bp hold", {ov8, ir8, d8}, {1'b1, 1'b0, 8'd4});
            end
            @(negedge clk);
            iv8 = 1'b0; or8 = 1'b1;
            @(negedge clk);
            chk("bp release", {ov8, ir8}, 2'b01);
            run_pair(9, 6, 3, 0, 3, "bp next");
            @(negedge clk);
            chk("bp no extra", ov8, 0);
        end

        // Reset in the middle of CALC discards the pair.
        @(negedge clk);
        x8 = 8'd200; y8 = 8'd3; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst state", {ov8, ir8, d8}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst ready", {ov8, ir8}, 2'b01);
        run_pair(9, 6, 3, 0, 3, "midrst next");
        @(negedge clk);
        chk("midrst no stale", ov8, 0);

        // Random back-to-back traffic on both widths in parallel.
        fork
            begin : r8
                int edt[$], ez[$], ek[$], acc[$];
                int t = 0, got = 0, sent = 0, first = -1;
                int dt, z, k, xv, yv, a_t;
                bit fired = 0;
                while (got < N8 && t < 60000) begin
                    @(negedge clk); t++;
                    if (fired) iv8 = 1'b0;
                    fired = 0;
                    or8 = ($urandom_range(3) != 0);
                    if (!iv8 && sent < N8 && $urandom_range(3) != 0) begin
                        xv = $urandom_range(255); yv = $urandom_range(255);
                        case ($urandom_range(7))
                            0: xv = 0;
                            1: yv = $urandom_range(1);
                            2: yv = xv;
                            default: ;
                        endcase
                        x8 = xv[7:0]; y8 = yv[7:0]; iv8 = 1'b1;
                    end
                    if (iv8 && ir8) begin
                        gcd_model(int'(x8), int'(y8), dt, z, k);
                        edt.push_back(dt); ez.push_back(z); ek.push_back(k); acc.push_back(t);
                        sent++; fired = 1;
                    end
                    if (ov8 && first < 0) first = t;
                    if (ov8 && or8) begin
                        if (edt.size() == 0) chk("r8 spurious result", 1, 0);
                        else begin
                            dt = edt.pop_front(); z = ez.pop_front();
                            k = ek.pop_front(); a_t = acc.pop_front();
                            chk("r8 dt", d8, dt);
                            chk("r8 zero", z8, z);
                            chk("r8 latency", first - a_t, k + 1);
`ifdef MDC_CYCLE_CNT_EN
                            chk("r8 cyc", c8, sat(k, CW8));
`endif
                        end
                        got++; first = -1;
                    end
                end
                iv8 = 1'b0;
                chk("r8 result count", got, N8);
                repeat (3) @(negedge clk);
                chk("r8 drained", {ov8, 31'(edt.size())}, 0);
            end
            begin : r16
                int edt[$], ez[$], ek[$], acc[$];
                int t = 0, got = 0, sent = 0, first = -1;
                int dt, z, k, xv, yv, a_t, tries;
                bit fired = 0;
                while (got < N16 && t < 60000) begin
                    @(negedge clk); t++;
                    if (fired) iv16 = 1'b0;
                    fired = 0;
                    or16 = ($urandom_range(3) != 0);
                    if (!iv16 && sent < N16 && $urandom_range(3) != 0) begin
                        tries = 0;
                        do begin
                            xv = $urandom_range(65535); yv = $urandom_range(65535);
                            case ($urandom_range(7))
                                0: yv = 0;
                                1: xv = $urandom_range(1);
                                2: xv = yv;
                                default: ;
                            endcase
                            gcd_model(xv, yv, dt, z, k);
                            tries++;
                        end while (k > 400 && tries < 100);
                        if (k > 400) yv = xv;
                        x16 = xv[15:0]; y16 = yv[15:0]; iv16 = 1'b1;
                    end
                    if (iv16 && ir16) begin
                        gcd_model(int'(x16), int'(y16), dt, z, k);
                        edt.push_back(dt); ez.push_back(z); ek.push_back(k); acc.push_back(t);
                        sent++; fired = 1;
                    end
                    if (ov16 && first < 0) first = t;
                    if (ov16 && or16) begin
                        if (edt.size() == 0) chk("r16 spurious result", 1, 0);
                        else begin
                            dt = edt.pop_front(); z = ez.pop_front();
                            k = ek.pop_front(); a_t = acc.pop_front();
                            chk("r16 dt", d16, dt);
                            chk("r16 zero", z16, z);
                            chk("r16 latency", first - a_t, k + 1);
`ifdef MDC_CYCLE_CNT_EN
                            chk("r16 cyc", c16, sat(k, CW16));
`endif
                        end
                        got++; first = -1;
                    end
                end
                iv16 = 1'b0;
                chk("r16 result count", got, N16);
                repeat (3) @(negedge clk);
                chk("r16 drained", {ov16, 31'(edt.size())}, 0);
            end
        join

        // 255,1 on the 16-bit engine: its CNT_W=7 counter must stop at 127.
        @(negedge clk);
        x16 = 16'd255; y16 = 16'd1; iv16 = 1'b1; or16 = 1'b0;
        @(posedge clk); #1;
        iv16 = 1'b0;
        begin : sat16
            int n = 0;
            while (!ov16 && n < 1000) begin
                @(negedge clk); n++;
            end
            chk("sat16 cycles", n, 256);
            chk("sat16 dt", d16, 1);
`ifdef MDC_CYCLE_CNT_EN
            chk("sat16 cyc", c16, 127);
`endif
        end
        or16 = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
